// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search sequencer.
// Contents: sequencer state enum, S-RAM phase-select enum, plaintext byte limits,
// and helpers to classify a plaintext byte and map a state onto its phase.
package rc4_pkg;

  typedef enum logic [3:0] {
    StHold,
    StIdle,
    StInitGo,
    StInitWait,
    StShufGo,
    StShufWait,
    StDecGo,
    StDecWait,
    StCheck,
    StNextKey,
    StDoneOk,
    StDoneFail
  } state_e;

  typedef enum logic [1:0] {
    PhNone,
    PhInit,
    PhShuf,
    PhDec
  } phase_e;

  localparam logic [7:0] ByteLowA  = 8'h61;
  localparam logic [7:0] ByteLowZ  = 8'h7A;
  localparam logic [7:0] ByteSpace = 8'h20;

  // Plaintext is accepted only if every byte is a lowercase letter or a space.
  function automatic logic is_legal_byte(input logic [7:0] b);
    return ((b >= ByteLowA) && (b <= ByteLowZ)) || (b == ByteSpace);
  endfunction

  // Which phase owns the S-RAM port while the sequencer sits in a given state.
  function automatic phase_e phase_of(input state_e s);
    phase_e ph;
    ph = PhNone;
    case (s)
      StInitGo, StInitWait: ph = PhInit;
      StShufGo, StShufWait: ph = PhShuf;
      StDecGo, StDecWait:   ph = PhDec;
      default:              ph = PhNone;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/flopr_en.sv
// Generic enabled register with asynchronous active-high reset to zero.
// Ports: clk_i clock, rst_i async reset, en_i load enable, d_i next value, q_o state.
module flopr_en #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/rc4_smem_mux.sv
// 3:1 S-RAM port mux. The selected phase's address/data/write-enable pass straight
// through; with no phase selected the port is driven to all zeros.
// Ports: sel_i phase select, <phase>_{addr,data,wren}_i per-phase requests,
// s_{addr,data,wren}_o shared S-RAM port.
module rc4_smem_mux
  import rc4_pkg::*;
(
  input  phase_e     sel_i,
  input  logic [7:0] init_addr_i,
  input  logic [7:0] init_data_i,
  input  logic       init_wren_i,
  input  logic [7:0] shuf_addr_i,
  input  logic [7:0] shuf_data_i,
  input  logic       shuf_wren_i,
  input  logic [7:0] dec_addr_i,
  input  logic [7:0] dec_data_i,
  input  logic       dec_wren_i,
  output logic [7:0] s_addr_o,
  output logic [7:0] s_data_o,
  output logic       s_wren_o
);

  always_comb begin
    s_addr_o = 8'h00;
    s_data_o = 8'h00;
    s_wren_o = 1'b0;
    unique case (sel_i)
      PhInit: begin
        s_addr_o = init_addr_i;
        s_data_o = init_data_i;
        s_wren_o = init_wren_i;
      end
      PhShuf: begin
        s_addr_o = shuf_addr_i;
        s_data_o = shuf_data_i;
        s_wren_o = shuf_wren_i;
      end
      PhDec: begin
        s_addr_o = dec_addr_i;
        s_data_o = dec_data_i;
        s_wren_o = dec_wren_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_task_ctrl.sv
// RC4 key-search sequencer. For each candidate key it runs init, shuffle and decrypt
// in turn, owns the shared S-RAM port, and screens every decrypted byte. Stops on the
// first key whose plaintext is all lowercase/space, or after KEY_MAX has failed.
// Ports: clk/reset; go request; per-phase start pulses, finished inputs and S-RAM
// requests; muxed s_addr/s_data/s_wren; monitored d_wren/d_data; key; busy/found/fail.
module rc4_task_ctrl
  import rc4_pkg::*;
#(
  parameter int unsigned       KEY_W   = 24,
  parameter logic [KEY_W-1:0]  KEY_MAX = KEY_W'(24'h3FFFFF),
  parameter int unsigned       MSG_LEN = 32,
  parameter int unsigned       HOLDOFF = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             init_start,
  output logic             shuf_start,
  output logic             dec_start,
  input  logic             init_finished,
  input  logic             shuf_finished,
  input  logic             dec_finished,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       init_data,
  input  logic             init_wren,
  input  logic [7:0]       shuf_addr,
  input  logic [7:0]       shuf_data,
  input  logic             shuf_wren,
  input  logic [7:0]       dec_addr,
  input  logic [7:0]       dec_data,
  input  logic             dec_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_data,
  output logic             s_wren,
  input  logic             d_wren,
  input  logic [7:0]       d_data,
  output logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             found,
  output logic             fail
);

  localparam logic [9:0]       HoldLast = 10'(HOLDOFF - 1);
  localparam logic [5:0]       MsgLenW  = 6'(MSG_LEN);
  localparam logic [KEY_W-1:0] KeyOne   = KEY_W'(1);

  state_e state_q, state_d;
  phase_e ph_sel_q, ph_sel_d;
  logic   init_start_q, init_start_d;
  logic   shuf_start_q, shuf_start_d;
  logic   dec_start_q, dec_start_d;
  logic   found_q, found_d;
  logic   fail_q, fail_d;
  logic   bad_q, bad_d;

  logic [9:0]       hold_cnt_q, hold_cnt_d;
  logic             hold_cnt_en;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_en;
  logic [5:0]       wr_cnt_q, wr_cnt_d;
  logic             wr_cnt_en;

  logic clear_run, next_key, dec_write, bad_now;

  assign clear_run = (state_q == StIdle) && go;
  assign next_key  = (state_q == StNextKey);
  assign dec_write = (state_q == StDecWait) && d_wren;
  // A short or long message counts as bad even if every byte seen was legal.
  assign bad_now   = bad_q || (wr_cnt_q != MsgLenW);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StHold:     if (hold_cnt_q == HoldLast) state_d = StIdle;
      StIdle:     if (go) state_d = StInitGo;
      StInitGo:   state_d = StInitWait;
      StInitWait: if (init_finished) state_d = StShufGo;
      StShufGo:   state_d = StShufWait;
      StShufWait: if (shuf_finished) state_d = StDecGo;
      StDecGo:    state_d = StDecWait;
      StDecWait:  if (dec_finished) state_d = StCheck;
      StCheck: begin
        if (!bad_now)              state_d = StDoneOk;
        else if (key_q == KEY_MAX) state_d = StDoneFail;
        else                       state_d = StNextKey;
      end
      StNextKey:  state_d = StInitGo;
      StDoneOk, StDoneFail: if (!go) state_d = StIdle;
      default:    state_d = StHold;
    endcase
  end

  always_comb begin
    // Select tracks the next state so the registered value lines up with state_q.
    ph_sel_d     = phase_of(state_d);
    init_start_d = (state_q == StInitGo);
    shuf_start_d = (state_q == StShufGo);
    dec_start_d  = (state_q == StDecGo);

    found_d = found_q;
    fail_d  = fail_q;
    if (clear_run) begin
      found_d = 1'b0;
      fail_d  = 1'b0;
    end else if (state_q == StCheck) begin
      if (state_d == StDoneOk)   found_d = 1'b1;
      if (state_d == StDoneFail) fail_d  = 1'b1;
    end

    bad_d = bad_q;
    if (clear_run || next_key) begin
      bad_d = 1'b0;
    end else if (dec_write && !is_legal_byte(d_data)) begin
      bad_d = 1'b1;
    end else if ((state_q == StCheck) && bad_now) begin
      bad_d = 1'b1;
    end

    hold_cnt_en = (state_q == StHold);
    hold_cnt_d  = hold_cnt_q + 10'd1;

    key_en = clear_run || (next_key && (key_q != KEY_MAX));
    key_d  = clear_run ? '0 : key_q + KeyOne;

    wr_cnt_en = clear_run || next_key || dec_write;
    wr_cnt_d  = (clear_run || next_key) ? 6'd0 : wr_cnt_q + 6'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StHold;
      ph_sel_q     <= PhNone;
      init_start_q <= 1'b0;
      shuf_start_q <= 1'b0;
      dec_start_q  <= 1'b0;
      found_q      <= 1'b0;
      fail_q       <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_sel_q     <= ph_sel_d;
      init_start_q <= init_start_d;
      shuf_start_q <= shuf_start_d;
      dec_start_q  <= dec_start_d;
      found_q      <= found_d;
      fail_q       <= fail_d;
      bad_q        <= bad_d;
    end
  end

  flopr_en #(.Width(10)) u_hold_cnt (
    .clk_i(clk), .rst_i(reset), .en_i(hold_cnt_en), .d_i(hold_cnt_d), .q_o(hold_cnt_q)
  );

  flopr_en #(.Width(KEY_W)) u_key (
    .clk_i(clk), .rst_i(reset), .en_i(key_en), .d_i(key_d), .q_o(key_q)
  );

  flopr_en #(.Width(6)) u_wr_cnt (
    .clk_i(clk), .rst_i(reset), .en_i(wr_cnt_en), .d_i(wr_cnt_d), .q_o(wr_cnt_q)
  );

  rc4_smem_mux u_smem_mux (
    .sel_i       (ph_sel_q),
    .init_addr_i (init_addr),
    .init_data_i (init_data),
    .init_wren_i (init_wren),
    .shuf_addr_i (shuf_addr),
    .shuf_data_i (shuf_data),
    .shuf_wren_i (shuf_wren),
    .dec_addr_i  (dec_addr),
    .dec_data_i  (dec_data),
    .dec_wren_i  (dec_wren),
    .s_addr_o    (s_addr),
    .s_data_o    (s_data),
    .s_wren_o    (s_wren)
  );

  assign init_start = init_start_q;
  assign shuf_start = shuf_start_q;
  assign dec_start  = dec_start_q;
  assign key        = key_q;
  assign found      = found_q;
  assign fail       = fail_q;
  assign busy       = !((state_q == StHold) || (state_q == StIdle) ||
                        (state_q == StDoneOk) || (state_q == StDoneFail));

endmodule
